// File: rtl/multi_cycle_control_unit_pkg.sv
// multi_cycle_control_unit_pkg: state, ALU-control, mux-select and opcode encodings shared by the control unit
package multi_cycle_control_unit_pkg;
    typedef enum logic [2:0] {
        STATE_IF   = 3'd0,
        STATE_ID   = 3'd1,
        STATE_EX   = 3'd2,
        STATE_MEM  = 3'd3,
        STATE_WB   = 3'd4,
        STATE_HALT = 3'd5
    } state_t;
    localparam logic [1:0] ALU_OP_ADD       = 2'd0;
    localparam logic [1:0] ALU_OP_BRANCH    = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT     = 2'd2;
    localparam logic [1:0] ALU_SRC_A_PC     = 2'd0;
    localparam logic [1:0] ALU_SRC_A_RS1    = 2'd1;
    localparam logic [1:0] ALU_SRC_A_OLD_PC = 2'd2;
    localparam logic [1:0] ALU_SRC_B_RS2    = 2'd0;
    localparam logic [1:0] ALU_SRC_B_FOUR   = 2'd1;
    localparam logic [1:0] ALU_SRC_B_IMM    = 2'd2;
    localparam logic [6:0] ARITHMETIC       = 7'b0110011;
    localparam logic [6:0] ARITHMETIC_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD             = 7'b0000011;
    localparam logic [6:0] JALR             = 7'b1100111;
    localparam logic [6:0] STORE            = 7'b0100011;
    localparam logic [6:0] BRANCH           = 7'b1100011;
    localparam logic [6:0] JAL              = 7'b1101111;
    localparam logic [6:0] ECALL            = 7'b1110011;
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       write_enable;
        logic       pc_to_reg;
        logic       pc_source;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       is_halted;
    } ctrl_t;
    function automatic logic is_exec_opcode(input logic [6:0] op);
        return op inside {ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JAL, JALR};
    endfunction
endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// multi_cycle_control_unit_if: control-unit <-> datapath signals; master is the control unit, slave the datapath
interface multi_cycle_control_unit_if;
    logic [6:0] part_of_inst;
    logic       bcond;
    logic       halt_req;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       write_enable;
    logic       pc_to_reg;
    logic       pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_halted;
    logic [2:0] state;
    modport master (
        input  part_of_inst, bcond, halt_req, mem_ready,
        output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               write_enable, pc_to_reg, pc_source, alu_src_a, alu_src_b, alu_op, is_halted, state
    );
    modport slave (
        output part_of_inst, bcond, halt_req, mem_ready,
        input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               write_enable, pc_to_reg, pc_source, alu_src_a, alu_src_b, alu_op, is_halted, state
    );
endinterface

// File: rtl/multi_cycle_control_unit_control_state_decode.sv
// control_state_decode: combinational Moore decode of (state, opcode) into datapath controls
// MEM_HANDSHAKE_EN: IF write strobes wait for mem_ready
module control_state_decode
    import multi_cycle_control_unit_pkg::*;
(
    input  state_t     i_state,
    input  logic [6:0] i_opcode,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);
    logic w_rdy;
`ifdef MEM_HANDSHAKE_EN
    assign w_rdy = i_mem_ready;
`else
    logic w_unused;
    assign w_unused = i_mem_ready;
    assign w_rdy = 1'b1;
`endif
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            STATE_IF: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = ALU_SRC_B_FOUR;
                o_ctrl.ir_write  = w_rdy;
                o_ctrl.pc_write  = w_rdy;
            end
            STATE_ID: begin
                o_ctrl.alu_src_a = ALU_SRC_A_OLD_PC;
                o_ctrl.alu_src_b = ALU_SRC_B_IMM;
            end
            STATE_EX: begin
                case (i_opcode)
                    ARITHMETIC: begin
                        o_ctrl.alu_src_a = ALU_SRC_A_RS1;
                        o_ctrl.alu_op    = ALU_OP_FUNCT;
                    end
                    ARITHMETIC_IMM: begin
                        o_ctrl.alu_src_a = ALU_SRC_A_RS1;
                        o_ctrl.alu_src_b = ALU_SRC_B_IMM;
                        o_ctrl.alu_op    = ALU_OP_FUNCT;
                    end
                    LOAD, STORE: begin
                        o_ctrl.alu_src_a = ALU_SRC_A_RS1;
                        o_ctrl.alu_src_b = ALU_SRC_B_IMM;
                    end
                    BRANCH: begin
                        o_ctrl.alu_src_a     = ALU_SRC_A_RS1;
                        o_ctrl.alu_op        = ALU_OP_BRANCH;
                        o_ctrl.pc_write_cond = 1'b1;
                        o_ctrl.pc_source     = 1'b1;
                    end
                    JAL: begin
                        o_ctrl.pc_write     = 1'b1;
                        o_ctrl.pc_source    = 1'b1;
                        o_ctrl.write_enable = 1'b1;
                        o_ctrl.pc_to_reg    = 1'b1;
                    end
                    JALR: begin
                        o_ctrl.alu_src_a    = ALU_SRC_A_RS1;
                        o_ctrl.alu_src_b    = ALU_SRC_B_IMM;
                        o_ctrl.pc_write     = 1'b1;
                        o_ctrl.write_enable = 1'b1;
                        o_ctrl.pc_to_reg    = 1'b1;
                    end
                    default: ;
                endcase
            end
            STATE_MEM: begin
                o_ctrl.i_or_d    = 1'b1;
                o_ctrl.mem_read  = i_opcode == LOAD;
                o_ctrl.mem_write = i_opcode == STORE;
            end
            STATE_WB: begin
                o_ctrl.write_enable = 1'b1;
                o_ctrl.mem_to_reg   = i_opcode == LOAD;
            end
            STATE_HALT: o_ctrl.is_halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: IF/ID/EX/MEM/WB/HALT sequencer for the multi-cycle RV32I datapath
// MEM_HANDSHAKE_EN: IF and MEM hold until mem_ready
module multi_cycle_control_unit
    import multi_cycle_control_unit_pkg::*;
(
    input logic                        clk,
    input logic                        reset,
    multi_cycle_control_unit_if.master bus
);
    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_rdy;
    logic   w_unused;
    // bcond is consumed by the datapath PC-enable logic, not by the sequencer
    assign w_unused = bus.bcond;
`ifdef MEM_HANDSHAKE_EN
    assign w_rdy = bus.mem_ready;
`else
    assign w_rdy = 1'b1;
`endif
    control_state_decode u_decode (
        .i_state    (r_state),
        .i_opcode   (bus.part_of_inst),
        .i_mem_ready(bus.mem_ready),
        .o_ctrl     (w_ctrl)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= STATE_IF;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = STATE_IF;
        case (r_state)
            STATE_IF:   w_next = w_rdy ? STATE_ID : STATE_IF;
            STATE_ID:   w_next = (bus.part_of_inst == ECALL) ? (bus.halt_req ? STATE_HALT : STATE_IF) :
                                 is_exec_opcode(bus.part_of_inst) ? STATE_EX : STATE_IF;
            STATE_EX:   w_next = (bus.part_of_inst inside {ARITHMETIC, ARITHMETIC_IMM}) ? STATE_WB :
                                 (bus.part_of_inst inside {LOAD, STORE}) ? STATE_MEM : STATE_IF;
            STATE_MEM:  w_next = !w_rdy ? STATE_MEM : (bus.part_of_inst == LOAD) ? STATE_WB : STATE_IF;
            STATE_WB:   w_next = STATE_IF;
            STATE_HALT: w_next = STATE_HALT;
            default:    w_next = STATE_IF;
        endcase
    end
    // reset masks every architectural write so nothing commits on the edge reset is released
    assign bus.pc_write      = w_ctrl.pc_write & ~reset;
    assign bus.pc_write_cond = w_ctrl.pc_write_cond & ~reset;
    assign bus.ir_write      = w_ctrl.ir_write & ~reset;
    assign bus.mem_write     = w_ctrl.mem_write & ~reset;
    assign bus.write_enable  = w_ctrl.write_enable & ~reset;
    assign bus.i_or_d        = w_ctrl.i_or_d;
    assign bus.mem_read      = w_ctrl.mem_read;
    assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
    assign bus.pc_to_reg     = w_ctrl.pc_to_reg;
    assign bus.pc_source     = w_ctrl.pc_source;
    assign bus.alu_src_a     = w_ctrl.alu_src_a;
    assign bus.alu_src_b     = w_ctrl.alu_src_b;
    assign bus.alu_op        = w_ctrl.alu_op;
    assign bus.is_halted     = w_ctrl.is_halted;
    assign bus.state         = r_state;
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb_multi_cycle_control_unit: directed checks of the multi-cycle control FSM
module tb_multi_cycle_control_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    multi_cycle_control_unit_if bus();
    multi_cycle_control_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.part_of_inst = 7'h33;
        bus.bcond = 1'b0;
        bus.halt_req = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        n_cmp++; if (bus.pc_write !== 1'b0 || bus.ir_write !== 1'b0) begin n_err++; $display("FAIL reset_writes: got pc_write=%b ir_write=%b want 0 0", bus.pc_write, bus.ir_write); end
        n_cmp++; if (bus.mem_read !== 1'b1 || bus.alu_src_b !== 2'd1) begin n_err++; $display("FAIL reset_if_outputs: got mem_read=%b alu_src_b=%0d want 1 1", bus.mem_read, bus.alu_src_b); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.pc_write !== 1'b1 || bus.ir_write !== 1'b1) begin n_err++; $display("FAIL released_if_writes: got pc_write=%b ir_write=%b want 1 1", bus.pc_write, bus.ir_write); end
    endtask

    task automatic test_add;
        logic [2:0] st [5];
        logic we [5];
        st = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        we = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.part_of_inst = 7'h33;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.state !== st[i]) begin n_err++; $display("FAIL add_state[%0d]: got %0d want %0d", i, bus.state, st[i]); end
            n_cmp++; if (bus.write_enable !== we[i]) begin n_err++; $display("FAIL add_we[%0d]: got %b want %b", i, bus.write_enable, we[i]); end
            if (i == 2) begin
                n_cmp++; if (bus.alu_op !== 2'd2 || bus.alu_src_a !== 2'd1 || bus.alu_src_b !== 2'd0) begin n_err++; $display("FAIL add_ex: got op=%0d a=%0d b=%0d want 2 1 0", bus.alu_op, bus.alu_src_a, bus.alu_src_b); end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_load;
        logic [2:0] st [6];
        st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        bus.part_of_inst = 7'h03;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (bus.state !== st[i]) begin n_err++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.state, st[i]); end
            if (i == 2) begin
                n_cmp++; if (bus.alu_src_b !== 2'd2 || bus.alu_op !== 2'd0) begin n_err++; $display("FAIL lw_ex: got b=%0d op=%0d want 2 0", bus.alu_src_b, bus.alu_op); end
            end
            if (i == 3) begin
                n_cmp++; if (bus.mem_read !== 1'b1 || bus.i_or_d !== 1'b1 || bus.mem_write !== 1'b0) begin n_err++; $display("FAIL lw_mem: got rd=%b iord=%b wr=%b want 1 1 0", bus.mem_read, bus.i_or_d, bus.mem_write); end
            end
            if (i == 4) begin
                n_cmp++; if (bus.mem_to_reg !== 1'b1 || bus.write_enable !== 1'b1) begin n_err++; $display("FAIL lw_wb: got m2r=%b we=%b want 1 1", bus.mem_to_reg, bus.write_enable); end
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_branch(input logic bc);
        logic [2:0] st [4];
        st = '{3'd0, 3'd1, 3'd2, 3'd0};
        bus.part_of_inst = 7'h63;
        bus.bcond = bc;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.state !== st[i]) begin n_err++; $display("FAIL beq%0d_state[%0d]: got %0d want %0d", bc, i, bus.state, st[i]); end
            if (i == 1) begin
                n_cmp++; if (bus.alu_src_a !== 2'd2 || bus.alu_src_b !== 2'd2 || bus.pc_write !== 1'b0) begin n_err++; $display("FAIL beq%0d_id: got a=%0d b=%0d pcw=%b want 2 2 0", bc, bus.alu_src_a, bus.alu_src_b, bus.pc_write); end
            end
            if (i == 2) begin
                n_cmp++; if (bus.pc_write_cond !== 1'b1 || bus.pc_source !== 1'b1 || bus.alu_op !== 2'd1 || bus.pc_write !== 1'b0) begin n_err++; $display("FAIL beq%0d_ex: got pwc=%b src=%b op=%0d pcw=%b want 1 1 1 0", bc, bus.pc_write_cond, bus.pc_source, bus.alu_op, bus.pc_write); end
            end
            if (i < 3) tick();
        end
        bus.bcond = 1'b0;
    endtask

    task automatic test_jumps;
        bus.part_of_inst = 7'h6F;
        tick();
        tick();
        n_cmp++; if (bus.state !== 3'd2 || bus.pc_write !== 1'b1 || bus.pc_source !== 1'b1 || bus.pc_to_reg !== 1'b1 || bus.write_enable !== 1'b1) begin n_err++; $display("FAIL jal_ex: got st=%0d pcw=%b src=%b p2r=%b we=%b want 2 1 1 1 1", bus.state, bus.pc_write, bus.pc_source, bus.pc_to_reg, bus.write_enable); end
        tick();
        bus.part_of_inst = 7'h67;
        n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL jal_done: got %0d want 0", bus.state); end
        tick();
        tick();
        n_cmp++; if (bus.state !== 3'd2 || bus.pc_write !== 1'b1 || bus.pc_source !== 1'b0 || bus.alu_src_a !== 2'd1 || bus.alu_src_b !== 2'd2 || bus.pc_to_reg !== 1'b1) begin n_err++; $display("FAIL jalr_ex: got st=%0d pcw=%b src=%b a=%0d b=%0d p2r=%b want 2 1 0 1 2 1", bus.state, bus.pc_write, bus.pc_source, bus.alu_src_a, bus.alu_src_b, bus.pc_to_reg); end
        tick();
        n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL jalr_done: got %0d want 0", bus.state); end
    endtask

    task automatic test_nop_and_ecall;
        bus.part_of_inst = 7'h7F;
        tick();
        tick();
        n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL unknown_op: got %0d want 0", bus.state); end
        bus.part_of_inst = 7'h73;
        bus.halt_req = 1'b0;
        tick();
        n_cmp++; if (bus.state !== 3'd1) begin n_err++; $display("FAIL ecall_id: got %0d want 1", bus.state); end
        tick();
        n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL ecall_nohalt: got %0d want 0", bus.state); end
    endtask

    task automatic test_halt;
        bus.part_of_inst = 7'h73;
        bus.halt_req = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            n_cmp++; if (bus.state !== 3'd5 || bus.is_halted !== 1'b1 || bus.pc_write !== 1'b0 || bus.ir_write !== 1'b0 || bus.write_enable !== 1'b0) begin n_err++; $display("FAIL halt_hold[%0d]: got st=%0d halted=%b pcw=%b irw=%b we=%b want 5 1 0 0 0", i, bus.state, bus.is_halted, bus.pc_write, bus.ir_write, bus.write_enable); end
            tick();
        end
        bus.halt_req = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.state !== 3'd0 || bus.is_halted !== 1'b0) begin n_err++; $display("FAIL halt_reset: got st=%0d halted=%b want 0 0", bus.state, bus.is_halted); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_store_and_reset;
        logic [2:0] st [5];
        st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        bus.part_of_inst = 7'h23;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.state !== st[i]) begin n_err++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, bus.state, st[i]); end
            if (i == 3) begin
                n_cmp++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.i_or_d !== 1'b1) begin n_err++; $display("FAIL sw_mem: got wr=%b rd=%b iord=%b want 1 0 1", bus.mem_write, bus.mem_read, bus.i_or_d); end
            end
            if (i < 4) tick();
        end
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.state !== 3'd0 || bus.mem_write !== 1'b0) begin n_err++; $display("FAIL sw_async_reset: got st=%0d wr=%b want 0 0", bus.state, bus.mem_write); end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL sw_after_reset: got %0d want 0", bus.state); end
    endtask

`ifdef MEM_HANDSHAKE_EN
    task automatic test_handshake;
        bus.part_of_inst = 7'h23;
        bus.mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.state !== 3'd0 || bus.ir_write !== 1'b0 || bus.pc_write !== 1'b0 || bus.mem_read !== 1'b1) begin n_err++; $display("FAIL hs_if_wait[%0d]: got st=%0d irw=%b pcw=%b rd=%b want 0 0 0 1", i, bus.state, bus.ir_write, bus.pc_write, bus.mem_read); end
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        n_cmp++; if (bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1) begin n_err++; $display("FAIL hs_if_ready: got irw=%b pcw=%b want 1 1", bus.ir_write, bus.pc_write); end
        tick();
        tick();
        bus.mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.state !== 3'd3 || bus.mem_write !== 1'b1) begin n_err++; $display("FAIL hs_mem_wait[%0d]: got st=%0d wr=%b want 3 1", i, bus.state, bus.mem_write); end
            tick();
        end
        bus.mem_ready = 1'b1;
        tick();
        n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL hs_mem_done: got %0d want 0", bus.state); end
    endtask
`else
    task automatic test_handshake;
        logic [2:0] st [5];
        st = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        bus.part_of_inst = 7'h13;
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++; if (bus.ir_write !== 1'b1) begin n_err++; $display("FAIL nohs_irw: got %b want 1", bus.ir_write); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.state !== st[i]) begin n_err++; $display("FAIL nohs_addi_state[%0d]: got %0d want %0d", i, bus.state, st[i]); end
            if (i < 4) tick();
        end
        bus.mem_ready = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_load();
        test_branch(1'b0);
        test_branch(1'b1);
        test_jumps();
        test_nop_and_ecall();
        test_store_and_reset();
        test_handshake();
        test_halt();
        test_add();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
